cuckoo_lookup_sched: RTL and testbench

//  Issue controller for the L12 cuckoo lookup pipeline (case + nocase lanes) in the payload engine.

---
 rtl/payload_engine_pkg.sv | 29 ++
 rtl/sched_result_fifo.sv | 57 +++++
 rtl/cuckoo_lookup_sched.sv | 117 +++++++++++
 tb/tb_cuckoo_lookup_sched.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/payload_engine_pkg.sv
// Shared types and sizing for the payload-engine cuckoo lookup scheduler.
package payload_engine_pkg;

  localparam int unsigned WIN_W    = 160;
  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned OFF_W    = 16;
  localparam int unsigned PID_W    = 8;
  localparam int unsigned HIT_W    = 8;

  typedef struct packed {
    logic [PID_W-1:0] pkt_id;
    logic [OFF_W-1:0] offset;
    logic [HIT_W-1:0] hit;
  } match_rec_t;

  typedef struct packed {
    logic             valid;
    logic [PID_W-1:0] pkt_id;
    logic [OFF_W-1:0] offset;
  } tag_t;

  localparam int unsigned REC_W = $bits(match_rec_t);

  // A lookup hits when either lane reports any compare match; suffix bits alone never qualify.
  function automatic logic is_hit(input logic [1:0] cmp, input logic [1:0] cmp_nc);
    return (|cmp) | (|cmp_nc);
  endfunction

endpackage

// File: rtl/sched_result_fifo.sv
// Synchronous result FIFO; head word is presented from storage and zeroed while empty.
module sched_result_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32,
  parameter int unsigned CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     push_data,
  input  logic             pop,
  output logic [W-1:0]     pop_data,
  output logic             valid,
  output logic [CNT_W-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             push_ok;
  logic             pop_ok;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign push_ok  = push & (cnt != CNT_W'(DEPTH));
  assign pop_ok   = pop & (cnt != '0);
  assign valid    = (cnt != '0);
  assign count    = cnt;
  assign pop_data = valid ? mem[rd_ptr] : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop_ok) rd_ptr <= ptr_inc(rd_ptr);
      case ({push_ok, pop_ok})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/cuckoo_lookup_sched.sv
// Issue controller for the L12 cuckoo lookup pipeline: credit-gated window issue,
// in-flight tag tracking and hit collection into a result FIFO.
module cuckoo_lookup_sched
  import payload_engine_pkg::*;
#(
  parameter int unsigned RES_DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             win_valid,
  input  logic [WIN_W-1:0] win_data,
  input  logic             win_last,
  output logic             win_ready,
  input  logic             pause,
  output logic             eng_enable,
  output logic [WIN_W-1:0] eng_win,
  output logic [WIN_W-1:0] eng_win_cmp,
  input  logic [1:0]       eng_cmp,
  input  logic [1:0]       eng_sfx,
  input  logic [1:0]       eng_cmp_nc,
  input  logic [1:0]       eng_sfx_nc,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PID_W-1:0] m_pkt_id,
  output logic [OFF_W-1:0] m_offset,
  output logic [7:0]       m_hit,
  output logic             busy
);

  localparam int unsigned CNT_W = $clog2(RES_DEPTH + 1);

  logic             run;
  tag_t             tag_pipe [PIPE_LAT];
  tag_t             res_tag;
  logic [WIN_W-1:0] win_dly  [PIPE_LAT-1];
  logic [PID_W-1:0] pkt_id;
  logic [OFF_W-1:0] offset;
  logic [CNT_W-1:0] inflight;
  logic [CNT_W-1:0] fifo_cnt;
  logic [CNT_W-1:0] fifo_free;
  logic             accept;
  logic             push;
  logic             pop;
  match_rec_t       push_rec;
  match_rec_t       head_rec;
  logic [REC_W-1:0] head_bits;

  always_comb begin
    inflight = '0;
    for (int unsigned i = 0; i < PIPE_LAT; i++) begin
      inflight = inflight + CNT_W'(tag_pipe[i].valid);
    end
  end

  // Every in-flight lookup holds a reserved FIFO slot, so a full pipe of hits always fits.
  // Only registered state feeds the credit check; m_ready never reaches win_ready.
  assign fifo_free  = CNT_W'(RES_DEPTH) - fifo_cnt;
  assign win_ready  = run & ~pause & (fifo_free > inflight);
  assign accept     = win_valid & win_ready;
  assign eng_enable = accept;
  assign eng_win    = win_data;
  assign eng_win_cmp = win_dly[PIPE_LAT-2];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run    <= 1'b0;
      pkt_id <= '0;
      offset <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_pipe[i] <= '0;
      for (int unsigned i = 0; i < PIPE_LAT - 1; i++) win_dly[i] <= '0;
    end else begin
      run         <= 1'b1;
      tag_pipe[0] <= '{valid: accept, pkt_id: pkt_id, offset: offset};
      for (int unsigned i = 1; i < PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      win_dly[0] <= win_data;
      for (int unsigned i = 1; i < PIPE_LAT - 1; i++) win_dly[i] <= win_dly[i-1];
      if (accept) begin
        if (win_last) begin
          offset <= '0;
          pkt_id <= pkt_id + 1'b1;
        end else begin
          offset <= offset + 1'b1;
        end
      end
    end
  end

  // Compare outputs are meaningful only when the matching tag reaches the last stage.
  assign res_tag  = tag_pipe[PIPE_LAT-1];
  assign push     = res_tag.valid & is_hit(eng_cmp, eng_cmp_nc);
  assign push_rec = '{pkt_id: res_tag.pkt_id,
                      offset: res_tag.offset,
                      hit:    {eng_sfx_nc, eng_cmp_nc, eng_sfx, eng_cmp}};
  assign pop      = m_valid & m_ready;

  sched_result_fifo #(
    .DEPTH (RES_DEPTH),
    .W     (REC_W),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_rec),
    .pop       (pop),
    .pop_data  (head_bits),
    .valid     (m_valid),
    .count     (fifo_cnt)
  );

  assign head_rec = match_rec_t'(head_bits);
  assign m_pkt_id = head_rec.pkt_id;
  assign m_offset = head_rec.offset;
  assign m_hit    = head_rec.hit;
  assign busy     = (inflight != '0) | m_valid;

endmodule

// File: tb/tb_cuckoo_lookup_sched.sv
// Scoreboard bench for cuckoo_lookup_sched: randomized windows and engine results against a queue model.
module tb_cuckoo_lookup_sched;
  import payload_engine_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             win_valid, win_last, win_ready, pause;
  logic [WIN_W-1:0] win_data;
  logic             eng_enable;
  logic [WIN_W-1:0] eng_win, eng_win_cmp;
  logic [1:0]       eng_cmp, eng_sfx, eng_cmp_nc, eng_sfx_nc;
  logic             m_valid, m_ready, busy;
  logic [PID_W-1:0] m_pkt_id;
  logic [OFF_W-1:0] m_offset;
  logic [7:0]       m_hit;

  cuckoo_lookup_sched #(.RES_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .win_valid(win_valid), .win_data(win_data), .win_last(win_last),
    .win_ready(win_ready), .pause(pause), .eng_enable(eng_enable), .eng_win(eng_win),
    .eng_win_cmp(eng_win_cmp), .eng_cmp(eng_cmp), .eng_sfx(eng_sfx), .eng_cmp_nc(eng_cmp_nc),
    .eng_sfx_nc(eng_sfx_nc), .m_valid(m_valid), .m_ready(m_ready), .m_pkt_id(m_pkt_id),
    .m_offset(m_offset), .m_hit(m_hit), .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int kcnt = 0;
  int valid_pct = 0, ready_pct = 100, hit_pct = 100, last_pct = 0;
  int win_budget = 0, pause_after = 0, n_acc = 0, pops = 0;
  int first_mv_c = 0;
  bit pause_req = 0, mv_seen = 0;
  int unsigned mdl_pid = 0, mdl_off = 0;

  logic [31:0]      exp_q [$];
  logic [7:0]       preset_hits [$];
  bit               last_q [$];
  int               acc_hist [$];
  logic [7:0]       sched  [int];
  logic [WIN_W-1:0] wincmp [int];

  task automatic check(input string name, input logic [WIN_W-1:0] act, input logic [WIN_W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, kcnt);
    end
  endtask

  task automatic clear_model();
    win_budget = 0; pause_req = 0; pause_after = 0; n_acc = 0; pops = 0;
    mv_seen = 0; mdl_pid = 0; mdl_off = 0;
    exp_q.delete(); preset_hits.delete(); last_q.delete(); acc_hist.delete();
    sched.delete(); wincmp.delete();
  endtask

  task automatic apply_reset();
    @(negedge clk); #3;
    rst = 1'b1;
    clear_model();
    repeat (2) @(negedge clk);
    #4 rst = 1'b0;
  endtask

  task automatic wait_drain(input int max_c, input string name);
    bit done = 0;
    for (int i = 0; i < max_c && !done; i++) begin
      @(negedge clk); #3;
      done = (win_budget == 0) && (exp_q.size() == 0) && !busy;
    end
    check(name, done, 1'b1);
  endtask

  initial forever @(posedge clk) kcnt++;

  // Driver: inputs change on the falling edge, the upcoming rising edge decides acceptance.
  initial begin
    int cyc;
    logic acc;
    logic [7:0] h;
    win_valid = 0; win_last = 0; win_data = '0; pause = 0; m_ready = 0;
    {eng_sfx_nc, eng_cmp_nc, eng_sfx, eng_cmp} = '0;
    forever begin
      @(negedge clk);
      cyc       = kcnt;
      pause     = pause_req;
      m_ready   = ($urandom_range(99) < ready_pct);
      win_valid = (win_budget > 0) && ($urandom_range(99) < valid_pct);
      win_data  = {$urandom, $urandom, $urandom, $urandom, $urandom};
      win_last  = (last_q.size() != 0) ? last_q[0] : ($urandom_range(99) < last_pct);
      if (sched.exists(cyc)) begin
        {eng_sfx_nc, eng_cmp_nc, eng_sfx, eng_cmp} = sched[cyc];
        sched.delete(cyc);
      end else begin
        {eng_sfx_nc, eng_cmp_nc, eng_sfx, eng_cmp} = 8'($urandom) | 8'h11;
      end
      #1;
      if (rst) continue;
      acc = win_valid & win_ready;
      if (pause) check("pause_win_ready", win_ready, 1'b0);
      check("eng_enable", eng_enable, acc);
      if (wincmp.exists(cyc)) begin
        check("eng_win_cmp", eng_win_cmp, wincmp[cyc]);
        wincmp.delete(cyc);
      end
      if (acc) begin
        check("eng_win", eng_win, win_data);
        if (preset_hits.size() != 0) h = preset_hits.pop_front();
        else begin
          h = 8'($urandom);
          if ($urandom_range(99) >= hit_pct) h = h & 8'hCC;
          else if (h[1:0] == 2'b00 && h[5:4] == 2'b00) h[0] = 1'b1;
        end
        sched[cyc + PIPE_LAT] = h;
        wincmp[cyc + PIPE_LAT - 1] = win_data;
        if (h[1:0] != 2'b00 || h[5:4] != 2'b00)
          exp_q.push_back({PID_W'(mdl_pid), OFF_W'(mdl_off), h});
        if (win_last) begin
          mdl_off = 0;
          mdl_pid = (mdl_pid + 1) % (1 << PID_W);
        end else begin
          mdl_off = (mdl_off + 1) % (1 << OFF_W);
        end
        acc_hist.push_back(cyc);
        n_acc++;
        win_budget--;
        if (last_q.size() != 0) void'(last_q.pop_front());
        if (pause_after > 0 && n_acc == pause_after) pause_req = 1;
      end
    end
  end

  // Monitor: the presented record must always be the oldest outstanding expected hit.
  initial forever begin
    @(negedge clk); #2;
    if (!rst && m_valid) begin
      if (!mv_seen) begin
        mv_seen = 1;
        first_mv_c = kcnt;
      end
      if (exp_q.size() == 0) check("rec_unexpected", m_valid, 1'b0);
      else begin
        check("rec", {m_pkt_id, m_offset, m_hit}, exp_q[0]);
        if (m_ready) begin
          void'(exp_q.pop_front());
          pops++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish, %0d failed so far", fails);
    $fatal(1, "timeout");
  end

  initial begin
    bit seen;
    rst = 1'b1;
    #3;
    check("rst_win_ready", win_ready, 1'b0);
    check("rst_eng_enable", eng_enable, 1'b0);
    check("rst_eng_win_cmp", eng_win_cmp, '0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    @(negedge clk); #4 rst = 1'b0;

    // Three windows, only the second reports a case hit.
    preset_hits = '{8'h00, 8'h01, 8'h00};
    last_q = '{1'b0, 1'b0, 1'b0};
    valid_pct = 100; ready_pct = 100; win_budget = 3;
    wait_drain(60, "t1_drain");
    check("t1_pops", pops, 1);
    if (acc_hist.size() >= 2) check("t1_latency", first_mv_c - acc_hist[1], PIPE_LAT + 1);
    else check("t1_accepts", acc_hist.size(), 3);

    // Back-pressure: consumer stalled, all hits.
    apply_reset();
    ready_pct = 0; hit_pct = 100; valid_pct = 100; last_pct = 0; win_budget = 100;
    repeat (30) @(negedge clk);
    #3;
    check("t2_accepts", n_acc, DEPTH);
    check("t2_win_ready", win_ready, 1'b0);
    check("t2_m_valid", m_valid, 1'b1);
    win_budget = 0; ready_pct = 100;
    wait_drain(60, "t2_drain");
    check("t2_pops", pops, DEPTH);

    // Packet boundaries and packet-id wrap.
    apply_reset();
    last_q = '{1'b0, 1'b1, 1'b0, 1'b0};
    valid_pct = 100; ready_pct = 100; hit_pct = 100; win_budget = 4;
    wait_drain(60, "t3a_drain");
    last_pct = 100; win_budget = 300;
    wait_drain(2000, "t3b_drain");
    check("t3_pops", pops, 304);
    last_pct = 0;

    // Pause with three lookups in flight.
    apply_reset();
    pause_after = 3; valid_pct = 100; ready_pct = 100; hit_pct = 100; win_budget = 100;
    for (int i = 0; i < 50 && n_acc < 3; i++) @(negedge clk);
    @(negedge clk); #3;
    check("t4_busy_inflight", busy, 1'b1);
    repeat (20) @(negedge clk);
    #3;
    check("t4_accepts", n_acc, 3);
    check("t4_pops", pops, 3);
    check("t4_busy_idle", busy, 1'b0);

    // Asynchronous reset with stored records and lookups in flight.
    apply_reset();
    ready_pct = 0; valid_pct = 100; hit_pct = 100; win_budget = 4;
    seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk); #3;
      seen = m_valid;
    end
    check("t5_m_valid_before", seen, 1'b1);
    @(posedge clk); #2;
    check("t5_busy_before", busy, 1'b1);
    rst = 1'b1;
    clear_model();
    #1;
    check("t5_win_ready", win_ready, 1'b0);
    check("t5_eng_enable", eng_enable, 1'b0);
    check("t5_eng_win_cmp", eng_win_cmp, '0);
    check("t5_m_valid", m_valid, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_m_rec", {m_pkt_id, m_offset, m_hit}, '0);
    repeat (2) @(negedge clk);
    #4 rst = 1'b0;
    ready_pct = 100;
    repeat (20) @(negedge clk);
    #3;
    check("t5_no_records", pops, 0);
    check("t5_busy_after", busy, 1'b0);

    // Idle gaps with nonzero junk on the compare inputs, then a mixed random run.
    valid_pct = 30; ready_pct = 100; hit_pct = 50; win_budget = 60;
    wait_drain(1000, "t6_idle_drain");
    valid_pct = 70; ready_pct = 60; hit_pct = 60; last_pct = 15; win_budget = 400;
    wait_drain(5000, "t7_random_drain");
    check("t7_exp_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
